wishbone_memory_responder: RTL

- Wishbone B4 classic responder: word-addressed, byte-selectable RAM that serves one initiator port of the core (iBus or dBus).
- Target side of the bus the core drives: consumes ADR/DAT_MOSI/SEL/CYC/STB/WE, returns DAT_MISO/ACK/ERR.
- Deterministic, programmable wait states, so simulation benches and formal harnesses get a realistic, bounded-latency memory behind the CPU.

---
 rtl/wishbone_memory_responder_if.sv | 24 ++
 rtl/wishbone_memory_responder.sv | 117 +++++++++++
 2 files changed

// File: rtl/wishbone_memory_responder_if.sv
// Wishbone B4 classic bus bundle between one core initiator port and the memory responder.
interface wishbone_memory_responder_if;
    logic [29:0] wb_ADR;
    logic [31:0] wb_DAT_MOSI;
    logic [3:0]  wb_SEL;
    logic        wb_CYC;
    logic        wb_STB;
    logic        wb_WE;
    logic [2:0]  wb_CTI;
    logic [1:0]  wb_BTE;
    logic [31:0] wb_DAT_MISO;
    logic        wb_ACK;
    logic        wb_ERR;

    modport master (
        output wb_ADR, wb_DAT_MOSI, wb_SEL, wb_CYC, wb_STB, wb_WE, wb_CTI, wb_BTE,
        input  wb_DAT_MISO, wb_ACK, wb_ERR
    );

    modport slave (
        input  wb_ADR, wb_DAT_MOSI, wb_SEL, wb_CYC, wb_STB, wb_WE, wb_CTI, wb_BTE,
        output wb_DAT_MISO, wb_ACK, wb_ERR
    );
endinterface

// File: rtl/wishbone_memory_responder.sv
// Wishbone classic byte-selectable RAM responder with fixed wait states (IDLE -> WAIT -> RESP).
// Define WB_MEM_RANDOM_STALL_EN to add 0..3 LFSR-driven extra wait cycles per access.
module wishbone_memory_responder #(
    parameter int          ADDR_WIDTH  = 10,
    parameter int          WAIT_STATES = 2,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                        clk,
    input  logic                        reset,
    wishbone_memory_responder_if.slave  wb,
    output logic [1:0]                  o_dbg_state
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Handshake: a request is accepted on an IDLE edge with CYC && STB; exactly one
    // ACK or ERR pulse follows, and the initiator must drop STB on the edge it samples it.
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

    state_t      r_state, w_next;
    logic [4:0]  r_cnt, w_load;
    logic [29:0] r_adr, w_adr;
    logic [31:0] r_dat, w_dat;
    logic [3:0]  r_sel, w_sel;
    logic        r_we, w_we;
    logic        r_ack, r_err;
    logic [31:0] r_dat_miso;
    logic [31:0] r_mem [DEPTH];
    logic        w_accept, w_enter_resp, w_in_range, w_do_write;
    logic        w_unused;

    assign w_unused = ^{wb.wb_CTI, wb.wb_BTE, LFSR_SEED};

`ifdef WB_MEM_RANDOM_STALL_EN
    logic [15:0] r_lfsr;
    logic        w_fb;
    assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_lfsr <= LFSR_SEED;
        else        r_lfsr <= {r_lfsr[14:0], w_fb};
    end
    assign w_load = 5'(WAIT_STATES) + {3'b000, r_lfsr[1:0]};
`else
    assign w_load = 5'(WAIT_STATES);
`endif

    // With zero wait cycles the access completes on its acceptance edge, so use live bus values.
    assign w_accept = (r_state == S_IDLE) && wb.wb_CYC && wb.wb_STB;
    assign w_adr    = (r_state == S_IDLE) ? wb.wb_ADR      : r_adr;
    assign w_dat    = (r_state == S_IDLE) ? wb.wb_DAT_MOSI : r_dat;
    assign w_sel    = (r_state == S_IDLE) ? wb.wb_SEL      : r_sel;
    assign w_we     = (r_state == S_IDLE) ? wb.wb_WE       : r_we;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_adr   <= '0;
            r_dat   <= '0;
            r_sel   <= '0;
            r_we    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_cnt <= w_load;
                r_adr <= wb.wb_ADR;
                r_dat <= wb.wb_DAT_MOSI;
                r_sel <= wb.wb_SEL;
                r_we  <= wb.wb_WE;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 5'd1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept) w_next = (w_load == 5'd0) ? S_RESP : S_WAIT;
            S_WAIT:  if (!wb.wb_CYC) w_next = S_IDLE;
                     else if (r_cnt <= 5'd1) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_enter_resp = (w_next == S_RESP) && (r_state != S_RESP);
        w_in_range   = (w_adr[29:ADDR_WIDTH] == '0);
        w_do_write   = w_enter_resp && w_in_range && w_we;
    end

    always_ff @(posedge clk) begin
        if (w_do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (w_sel[i]) r_mem[w_adr[ADDR_WIDTH-1:0]][8*i +: 8] <= w_dat[8*i +: 8];
            end
        end
    end

    // Read data is driven only during a read ACK and is zero otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_dat_miso <= '0;
        end else begin
            r_ack      <= w_enter_resp && w_in_range;
            r_err      <= w_enter_resp && !w_in_range;
            r_dat_miso <= (w_enter_resp && w_in_range && !w_we) ? r_mem[w_adr[ADDR_WIDTH-1:0]] : '0;
        end
    end

    assign wb.wb_ACK      = r_ack;
    assign wb.wb_ERR      = r_err;
    assign wb.wb_DAT_MISO = r_dat_miso;
    assign o_dbg_state    = r_state;
endmodule
